seg_disp_sched: RTL and testbench



---
 rtl/seg_pkg.sv | 45 ++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/seg_disp_sched.sv | 178 +++++++++++++++++
 tb/tb_seg_disp_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment display scheduler.
package seg_pkg;

    localparam int SEG_BITS    = 64;
    localparam int FRAME_FIXED = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_DONE,
        ST_WAIT
    } seg_state_t;

    // LOAD + DONE plus two half-periods per shifted bit.
    function automatic int frame_len_f(input int clk_div);
        return FRAME_FIXED + 2 * SEG_BITS * clk_div;
    endfunction

    // Active-low segment byte {dp,g,f,e,d,c,b,a}; dot is active-high.
    function automatic logic [7:0] hex2seg_f(input logic [3:0] nibble, input logic dot);
        logic [6:0] w_seg;
        case (nibble)
            4'h0:    w_seg = 7'h40;
            4'h1:    w_seg = 7'h79;
            4'h2:    w_seg = 7'h24;
            4'h3:    w_seg = 7'h30;
            4'h4:    w_seg = 7'h19;
            4'h5:    w_seg = 7'h12;
            4'h6:    w_seg = 7'h02;
            4'h7:    w_seg = 7'h78;
            4'h8:    w_seg = 7'h00;
            4'h9:    w_seg = 7'h10;
            4'hA:    w_seg = 7'h08;
            4'hB:    w_seg = 7'h03;
            4'hC:    w_seg = 7'h46;
            4'hD:    w_seg = 7'h21;
            4'hE:    w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
        return {~dot, w_seg};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester just after the last grant has top priority.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_vld
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_k;

    // Scan from lowest priority to highest so the last hit wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        w_k       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_k = {1'b0, r_ptr} + (IW + 1)'(i);
            if (w_k >= (IW + 1)'(N)) begin
                w_k = w_k - (IW + 1)'(N);
            end
            if (req[w_k[IW-1:0]]) begin
                grant_idx = w_k[IW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && grant_vld) begin
            r_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/seg_disp_sched.sv
// Round-robins debug words onto the 8-digit display and serialises 64 segment bits.
//   state    | meaning
//   IDLE     | just out of reset, goes straight to LOAD
//   LOAD     | grant captured this cycle, encode and start shifting
//   SHIFT_LO | seg_clk low, current bit on seg_dout for CLK_DIV cycles
//   SHIFT_HI | seg_clk high for CLK_DIV cycles, then next bit or DONE
//   DONE     | frame latched (seg_en high), one cycle
//   WAIT     | idle until the refresh period expires
module seg_disp_sched
    import seg_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int CLK_DIV        = 2,
    parameter int REFRESH_CYCLES = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*8-1:0]       req_dot,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] cur_src,
    output logic                       busy,
    output logic                       seg_clk,
    output logic                       seg_clrn,
    output logic                       seg_dout,
    output logic                       seg_en
);

    localparam int FRAME_LEN = frame_len_f(CLK_DIV);
    localparam int SRC_W     = $clog2(NUM_REQ);
    localparam int RW        = $clog2(REFRESH_CYCLES);
    localparam int DW        = $clog2(CLK_DIV) + 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [5:0]    BIT_LAST     = 6'(SEG_BITS - 1);

    if (REFRESH_CYCLES < FRAME_LEN) begin : g_bad_refresh
        $error("REFRESH_CYCLES is shorter than one frame");
    end
    if (DATA_W != 32) begin : g_bad_width
        $error("DATA_W must be 32 (8 hex digits)");
    end
    if (NUM_REQ < 2 || CLK_DIV < 1) begin : g_bad_params
        $error("NUM_REQ must be >= 2 and CLK_DIV >= 1");
    end

    seg_state_t          r_state;
    logic [DATA_W-1:0]   r_word;
    logic [7:0]          r_dot;
    logic [RW-1:0]       r_refresh;
    logic [SEG_BITS-1:0] r_shift;
    logic [5:0]          r_bit;
    logic [DW-1:0]       r_div;
    logic [NUM_REQ-1:0]  r_ready;
    logic [SRC_W-1:0]    r_cur;
    logic                r_busy;
    logic                r_seg_clk;
    logic                r_clrn;
    logic                r_dout;
    logic                r_en;

    logic                w_goto_load;
    logic [SRC_W-1:0]    w_grant_idx;
    logic                w_grant_vld;
    logic [SEG_BITS-1:0] w_seg;
    logic [DATA_W-1:0]   w_sel_data;
    logic [7:0]          w_sel_dot;

    assign w_goto_load = (r_state == ST_IDLE) ||
                         (((r_state == ST_WAIT) || (r_state == ST_DONE)) && (r_refresh == REFRESH_LAST));

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_goto_load),
        .grant_idx (w_grant_idx),
        .grant_vld (w_grant_vld)
    );

    assign w_sel_data = req_data[int'(w_grant_idx) * DATA_W +: DATA_W];
    assign w_sel_dot  = req_dot[int'(w_grant_idx) * 8 +: 8];

    always_comb begin
        w_seg = '0;
        for (int k = 0; k < 8; k++) begin
            w_seg[8*k +: 8] = hex2seg_f(r_word[4*k +: 4], r_dot[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_word    <= '0;
            r_dot     <= '0;
            r_refresh <= '0;
            r_shift   <= '0;
            r_bit     <= '0;
            r_div     <= '0;
            r_ready   <= '0;
            r_cur     <= '0;
            r_busy    <= 1'b0;
            r_seg_clk <= 1'b0;
            r_clrn    <= 1'b0;
            r_dout    <= 1'b0;
            r_en      <= 1'b1;
        end else begin
            r_clrn    <= 1'b1;
            r_ready   <= '0;
            r_refresh <= w_goto_load ? '0 : r_refresh + RW'(1);
            case (r_state)
                ST_IDLE, ST_DONE, ST_WAIT: begin
                    // Grant is decided on the edge into LOAD so ready is a clean registered pulse.
                    if (w_goto_load) begin
                        r_state <= ST_LOAD;
                        if (w_grant_vld) begin
                            r_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx;
                            r_word  <= w_sel_data;
                            r_dot   <= w_sel_dot;
                            r_cur   <= w_grant_idx;
                        end
                    end else if (r_state == ST_DONE) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_LOAD: begin
                    r_state   <= ST_SHIFT_LO;
                    r_shift   <= w_seg;
                    r_dout    <= w_seg[SEG_BITS-1];
                    r_bit     <= '0;
                    r_div     <= '0;
                    r_busy    <= 1'b1;
                    r_en      <= 1'b0;
                    r_seg_clk <= 1'b0;
                end
                ST_SHIFT_LO: begin
                    if (r_div == DIV_LAST) begin
                        r_div     <= '0;
                        r_seg_clk <= 1'b1;
                        r_state   <= ST_SHIFT_HI;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                ST_SHIFT_HI: begin
                    if (r_div == DIV_LAST) begin
                        r_div     <= '0;
                        r_seg_clk <= 1'b0;
                        if (r_bit == BIT_LAST) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_en    <= 1'b1;
                        end else begin
                            r_state <= ST_SHIFT_LO;
                            r_bit   <= r_bit + 6'd1;
                            r_shift <= r_shift << 1;
                            r_dout  <= r_shift[SEG_BITS-2];
                        end
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign cur_src   = r_cur;
    assign busy      = r_busy;
    assign seg_clk   = r_seg_clk;
    assign seg_clrn  = r_clrn;
    assign seg_dout  = r_dout;
    assign seg_en    = r_en;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched: frame-timing and round-robin reference model.
module tb_seg_disp_sched;

    localparam int NUM_REQ        = 4;
    localparam int DATA_W         = 32;
    localparam int CLK_DIV        = 2;
    localparam int REFRESH_CYCLES = 300;
    localparam int BIT_CYC        = 2 * CLK_DIV;
    localparam int SHIFT_LEN      = 64 * BIT_CYC;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
    logic [NUM_REQ*8-1:0]      req_dot   = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [1:0]                cur_src;
    logic                      busy, seg_clk, seg_clrn, seg_dout, seg_en;

    always #5 clk = ~clk;

    seg_disp_sched #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .CLK_DIV        (CLK_DIV),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_dot   (req_dot),
        .req_ready (req_ready),
        .cur_src   (cur_src),
        .busy      (busy),
        .seg_clk   (seg_clk),
        .seg_clrn  (seg_clrn),
        .seg_dout  (seg_dout),
        .seg_en    (seg_en)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [7:0] seg_rom [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [63:0] expect_seg(input logic [31:0] w, input logic [7:0] d);
        logic [63:0] r;
        logic [7:0]  b;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            b = seg_rom[w[4*k +: 4]];
            r[8*k +: 8] = {~d[k], b[6:0]};
        end
        return r;
    endfunction

    // Reference model: phase = cycles since the last LOAD, -1 while in reset.
    int           phase = -1;
    logic [31:0]  m_word;
    logic [7:0]   m_dot;
    int           m_ptr;
    int           m_cur;
    logic [3:0]   m_ready;
    logic [63:0]  m_seg;

    logic [63:0]  obs_frame = '0;
    int           nbits = 0;
    logic         prev_clk = 1'b0;
    int           ready_cnt [NUM_REQ];

    logic [3:0]   drop_on_ready = '1;
    bit           rand_mode = 0;

    task automatic model_reset();
        m_word  = '0;
        m_dot   = '0;
        m_ptr   = 0;
        m_cur   = 0;
        m_ready = '0;
        m_seg   = expect_seg(32'h0, 8'h0);
    endtask

    task automatic model_load(input logic [3:0] v, input logic [127:0] d, input logic [31:0] dt);
        int idx;
        bit found;
        found = 0;
        m_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (m_ptr + i) % NUM_REQ;
            if (!found && v[idx]) begin
                found        = 1;
                m_ready[idx] = 1'b1;
                m_word       = d[idx*32 +: 32];
                m_dot        = dt[idx*8 +: 8];
                m_cur        = idx;
            end
        end
        if (found) m_ptr = (m_cur + 1) % NUM_REQ;
        m_seg = expect_seg(m_word, m_dot);
    endtask

    task automatic step();
        logic         p_rst;
        logic [3:0]   p_v;
        logic [127:0] p_d;
        logic [31:0]  p_dt;
        logic [9:0]   obs_o, exp_o;
        bit           b;
        int           q;
        p_rst = rst;
        p_v   = req_valid;
        p_d   = req_data;
        p_dt  = req_dot;
        @(posedge clk);
        #1;
        if (p_rst) begin
            phase = -1;
            model_reset();
        end else begin
            phase   = (phase < 0 || phase == REFRESH_CYCLES - 1) ? 0 : phase + 1;
            m_ready = '0;
            if (phase == 0) model_load(p_v, p_d, p_dt);
        end
        obs_o = {req_ready, cur_src, busy, seg_clk, seg_en, seg_clrn};
        if (phase < 0) begin
            exp_o = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
            chk("rst_outs", 64'(obs_o), 64'(exp_o));
            chk("rst_dout", 64'(seg_dout), 64'(0));
            nbits = 0;
        end else begin
            q = phase - 1;
            b = (phase >= 1) && (phase <= SHIFT_LEN);
            exp_o = {m_ready, 2'(m_cur), b, (b && ((q % BIT_CYC) >= CLK_DIV)), !b, 1'b1};
            chk("outs", 64'(obs_o), 64'(exp_o));
            if (b) chk("dout", 64'(seg_dout), 64'(m_seg[63 - q / BIT_CYC]));
            if (phase == 0) nbits = 0;
            if (seg_clk && !prev_clk) begin
                obs_frame = {obs_frame[62:0], seg_dout};
                nbits++;
            end
            if (phase == SHIFT_LEN + 1) begin
                chk("frame_bits", 64'(nbits), 64'(64));
                chk("frame", obs_frame, m_seg);
            end
        end
        prev_clk = seg_clk;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] === 1'b1) ready_cnt[i]++;
            if (m_ready[i] && drop_on_ready[i]) req_valid[i] = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 59) == 0) begin
                    req_valid[i]          = 1'b1;
                    req_data[i*32 +: 32]  = $urandom;
                    req_dot[i*8 +: 8]     = 8'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 1999) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to_phase(input int p);
        for (int k = 0; k < 2 * REFRESH_CYCLES; k++) begin
            if (phase == p) break;
            step();
        end
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
    endtask

    initial begin
        model_reset();
        clr_cnt();

        // idle frames after reset: all zeros, no grants
        run(3);
        rst = 1'b0;
        run(2 * REFRESH_CYCLES);
        chk("s1_no_ready", 64'(ready_cnt[0] + ready_cnt[1] + ready_cnt[2] + ready_cnt[3]), 64'(0));

        // single requester, then re-sent after valid drops
        clr_cnt();
        req_valid[0]      = 1'b1;
        req_data[31:0]    = 32'h1234ABCD;
        req_dot[7:0]      = 8'h00;
        run(3 * REFRESH_CYCLES);
        chk("s2_ready_pulses", 64'(ready_cnt[0]), 64'(1));

        // all valid from reset: grants 0,1,2,3,0
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        clr_cnt();
        drop_on_ready = '0;
        req_data  = {32'hDEAD0003, 32'h00C0FFEE, 32'h55AA1234, 32'h89ABCDEF};
        req_dot   = {8'hF0, 8'h0F, 8'h81, 8'h18};
        req_valid = '1;
        run(5 * REFRESH_CYCLES);
        req_valid = '0;
        drop_on_ready = '1;
        chk("s3_ready_r0", 64'(ready_cnt[0]), 64'(2));
        chk("s3_ready_r1", 64'(ready_cnt[1]), 64'(1));
        chk("s3_ready_r2", 64'(ready_cnt[2]), 64'(1));
        chk("s3_ready_r3", 64'(ready_cnt[3]), 64'(1));

        // mid-frame request, data changed after its grant
        clr_cnt();
        run_to_phase(50);
        req_valid[2]        = 1'b1;
        req_data[64 +: 32]  = 32'hFFFFFFFF;
        req_dot[16 +: 8]    = 8'h00;
        run_to_phase(0);
        req_data[64 +: 32]  = 32'h0;
        run(3 * REFRESH_CYCLES);
        chk("s4_ready_r2", 64'(ready_cnt[2]), 64'(1));

        // reset at bit 20 of a frame
        run_to_phase(1 + 20 * BIT_CYC);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(2 * REFRESH_CYCLES);

        // decimal point on digit 0
        clr_cnt();
        req_valid[1]       = 1'b1;
        req_data[32 +: 32] = 32'h0;
        req_dot[8 +: 8]    = 8'h01;
        run(2 * REFRESH_CYCLES);
        chk("s6_ready_r1", 64'(ready_cnt[1]), 64'(1));

        // randomized requesters
        rand_mode = 1;
        run(20 * REFRESH_CYCLES);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
